// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: edge-detected coins/selects, saturating credit,
// timed vend/deny hold. Define VEND_CHANGE_RETURN_EN to return leftover credit as change.
module vend_ctrl_param #(
  parameter int                              NUM_PRODUCTS = 4,
  parameter int                              NUM_COINS    = 3,
  parameter int                              CREDIT_W     = 8,
  parameter logic [NUM_COINS*CREDIT_W-1:0]    COIN_VALUES  = {8'd25, 8'd10, 8'd5},
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES       = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int                              CREDIT_MAX   = 95,
  parameter int                              HOLD_TICKS   = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    clk_en,
  input  logic [NUM_COINS-1:0]    coin,
  input  logic [NUM_PRODUCTS-1:0] sel,
  output logic [CREDIT_W-1:0]     credit,
  output logic [NUM_PRODUCTS-1:0] vend,
  output logic                    deny,
  output logic                    coin_rej,
  output logic [NUM_COINS-1:0]    change,
  output logic                    busy
);
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CREDIT_W:0] MAX_C = CREDIT_MAX[CREDIT_W:0];

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_DENY, S_CHANGE} state_t;

  state_t                  r_state, w_nxt_state;
  logic [NUM_COINS-1:0]    r_coin_q, w_coin_rise;
  logic [NUM_PRODUCTS-1:0] r_sel_q, w_sel_rise, w_sel_oh;
  logic [CREDIT_W-1:0]     r_credit, w_nxt_credit, w_coin_val, w_price;
  logic [CREDIT_W:0]       w_sum;
  logic                    w_sum_ok, w_afford;
  logic [NUM_PRODUCTS-1:0] r_vend, w_nxt_vend;
  logic                    r_deny, w_nxt_deny;
  logic                    r_coin_rej, w_nxt_rej;
  logic [HW-1:0]           r_hold, w_nxt_hold;

  assign w_coin_rise = coin & ~r_coin_q;
  assign w_sel_rise  = sel & ~r_sel_q;

  // Lowest-index edge wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    w_coin_val = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--)
      if (w_coin_rise[i]) w_coin_val = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
  end

  always_comb begin
    w_price  = '0;
    w_sel_oh = '0;
    for (int i = NUM_PRODUCTS - 1; i >= 0; i--)
      if (w_sel_rise[i]) begin
        w_price     = PRICES[i*CREDIT_W +: CREDIT_W];
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
  end

  assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_sum_ok = (w_sum <= MAX_C);
  assign w_afford = (r_credit >= w_price);

`ifdef VEND_CHANGE_RETURN_EN
  localparam logic [CREDIT_W-1:0] MIN_COIN = COIN_VALUES[CREDIT_W-1:0];

  logic [NUM_COINS-1:0] r_change, w_nxt_change, w_chg_oh;
  logic [CREDIT_W-1:0]  w_chg_val, w_chg_rem;
  logic                 w_chg_ok;

  // Values ascend by index, so the last fitting coin is the largest.
  always_comb begin
    w_chg_ok  = 1'b0;
    w_chg_oh  = '0;
    w_chg_val = '0;
    for (int j = 0; j < NUM_COINS; j++)
      if (COIN_VALUES[j*CREDIT_W +: CREDIT_W] <= r_credit) begin
        w_chg_ok    = 1'b1;
        w_chg_oh    = '0;
        w_chg_oh[j] = 1'b1;
        w_chg_val   = COIN_VALUES[j*CREDIT_W +: CREDIT_W];
      end
  end

  assign w_chg_rem = r_credit - w_chg_val;
`endif

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_credit = r_credit;
    w_nxt_vend   = r_vend;
    w_nxt_deny   = r_deny;
    w_nxt_rej    = 1'b0;
    w_nxt_hold   = r_hold;
`ifdef VEND_CHANGE_RETURN_EN
    w_nxt_change = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|w_coin_rise) begin
          if (w_sum_ok) w_nxt_credit = w_sum[CREDIT_W-1:0];
          else          w_nxt_rej    = 1'b1;
        end else if (|w_sel_rise) begin
          w_nxt_hold = HW'(HOLD_TICKS);
          if (w_afford) begin
            w_nxt_credit = r_credit - w_price;
            w_nxt_vend   = w_sel_oh;
            w_nxt_state  = S_VEND;
          end else begin
            w_nxt_deny  = 1'b1;
            w_nxt_state = S_DENY;
          end
        end
      end
      S_VEND, S_DENY: begin
        if (clk_en) begin
          if (r_hold <= HW'(1)) begin
            w_nxt_hold  = '0;
            w_nxt_vend  = '0;
            w_nxt_deny  = 1'b0;
            w_nxt_state = S_IDLE;
`ifdef VEND_CHANGE_RETURN_EN
            if (r_state == S_VEND && r_credit != '0) w_nxt_state = S_CHANGE;
`endif
          end else begin
            w_nxt_hold = r_hold - HW'(1);
          end
        end
      end
      S_CHANGE: begin
`ifdef VEND_CHANGE_RETURN_EN
        if (!w_chg_ok) begin
          w_nxt_state = S_IDLE;
        end else if (clk_en) begin
          w_nxt_change = w_chg_oh;
          w_nxt_credit = w_chg_rem;
          if (w_chg_rem < MIN_COIN) w_nxt_state = S_IDLE;
        end
`else
        w_nxt_state = S_IDLE;
`endif
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_coin_q   <= '0;
      r_sel_q    <= '0;
      r_credit   <= '0;
      r_vend     <= '0;
      r_deny     <= 1'b0;
      r_coin_rej <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_coin_q   <= coin;
      r_sel_q    <= sel;
      r_credit   <= w_nxt_credit;
      r_vend     <= w_nxt_vend;
      r_deny     <= w_nxt_deny;
      r_coin_rej <= w_nxt_rej;
      r_hold     <= w_nxt_hold;
    end
  end

`ifdef VEND_CHANGE_RETURN_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_change <= '0;
    else     r_change <= w_nxt_change;
  end

  assign change = r_change;
`else
  assign change = '0;
`endif

  assign credit   = r_credit;
  assign vend     = r_vend;
  assign deny     = r_deny;
  assign coin_rej = r_coin_rej;
  assign busy     = (r_state != S_IDLE);

endmodule
